dpr_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives both ports of the `dpr_sync` dual-port RAM.
- It is the initiator on the RAM interface: it converts a push/pop stream handshake into `din`/`add_wr`/`wr_en` and `add_rd`/`rd_en`/`blk_select` transactions.
- It returns the RAM's registered `dout` to the consumer with a valid strobe.
- It instantiates no storage; the RAM sits beside it at the top level.

---
 rtl/dpr_fifo_ctrl.sv | 85 ++++++++
 tb/tb_dpr_fifo_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dpr_fifo_ctrl.sv
// rtl/dpr_fifo_ctrl.sv - FIFO controller driving both ports of the dpr_sync dual-port RAM
// Optional sticky overflow/underflow outputs are enabled by defining DPR_FIFO_ERR_FLAGS_EN.
module dpr_fifo_ctrl #(
    parameter int MEM_WIDTH = 16,
    parameter int ADDR_SIZE = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [MEM_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [MEM_WIDTH-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   count,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_add_wr,
    output logic [ADDR_SIZE-1:0] ram_add_rd,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    input  logic [MEM_WIDTH-1:0] ram_dout
`ifdef DPR_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 wr_acc;
    logic                 rd_acc;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Gating with rst keeps the RAM strobes quiet for the whole reset pulse.
    assign wr_acc = push & ~full & ~rst;
    assign rd_acc = pop & ~empty & ~rst;

    assign ram_wr_en      = wr_acc;
    assign ram_din        = push_data;
    assign ram_add_wr     = wr_ptr;
    assign ram_rd_en      = rd_acc;
    assign ram_add_rd     = rd_ptr;
    assign ram_blk_select = wr_acc | rd_acc;
    assign pop_data       = ram_dout;

    // Pointers wrap by natural overflow since MEM_DEPTH == 2**ADDR_SIZE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pop_valid <= rd_acc;
        end
    end

`ifdef DPR_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end
`endif

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// tb/tb_dpr_fifo_ctrl.sv - directed self-checking bench for dpr_fifo_ctrl with a dpr_sync RAM model
module tb_dpr_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] push_data;
    logic        pop;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic [10:0] count;
    logic [15:0] ram_din;
    logic [9:0]  ram_add_wr;
    logic [9:0]  ram_add_rd;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic        ram_blk_select;
    logic [15:0] ram_dout;
`ifdef DPR_FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    dpr_fifo_ctrl #(.MEM_WIDTH(16), .ADDR_SIZE(10), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count),
        .ram_din(ram_din), .ram_add_wr(ram_add_wr), .ram_add_rd(ram_add_rd),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_blk_select(ram_blk_select), .ram_dout(ram_dout)
`ifdef DPR_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // Behavioural dpr_sync: registered read, write on the same edge.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_blk_select && ram_wr_en) mem[ram_add_wr] <= ram_din;
        if (ram_blk_select && ram_rd_en) ram_dout <= mem[ram_add_rd];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          mcount;
    logic [9:0]  mwp;
    logic [9:0]  mrp;
    logic [15:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 16'hDEAD;
        #1;
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_rd_en", 32'(ram_rd_en), 32'd0);
        check("rst_blk_sel", 32'(ram_blk_select), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        rst = 1'b0;
        mcount = 0; mwp = '0; mrp = '0; sb.delete();
    endtask

    // One cycle: apply request, check RAM-side strobes, then check state after the edge.
    task automatic drive(input logic p, input logic [15:0] d, input logic q, output logic [15:0] got);
        logic        wa;
        logic        ra;
        logic [15:0] exp_d;
        push = p; push_data = d; pop = q;
        exp_d = 16'h0;
        #1;
        wa = p && (mcount < 1024);
        ra = q && (mcount > 0);
        check("wr_en", 32'(ram_wr_en), 32'(wa));
        check("rd_en", 32'(ram_rd_en), 32'(ra));
        check("blk_sel", 32'(ram_blk_select), 32'(wa | ra));
        if (wa) check("add_wr", 32'(ram_add_wr), 32'(mwp));
        if (ra) check("add_rd", 32'(ram_add_rd), 32'(mrp));
        @(posedge clk); #1;
        if (ra) begin exp_d = sb.pop_front(); mrp = mrp + 10'd1; end
        if (wa) begin sb.push_back(d); mwp = mwp + 10'd1; end
        mcount = mcount + int'(wa) - int'(ra);
        check("count", 32'(count), 32'(mcount));
        check("full", 32'(full), 32'(mcount == 1024));
        check("empty", 32'(empty), 32'(mcount == 0));
        check("pop_valid", 32'(pop_valid), 32'(ra));
        if (ra) check("pop_data", 32'(pop_data), 32'(exp_d));
        got = pop_data;
        push = 1'b0; pop = 1'b0;
    endtask

    logic [15:0] got;
    logic [15:0] exp_seq;

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        @(posedge clk); #1;
        do_reset();

        // Ordering and latency
        drive(1'b1, 16'h0011, 1'b0, got);
        drive(1'b1, 16'h0022, 1'b0, got);
        drive(1'b1, 16'h0033, 1'b0, got);
        check("ord_count", 32'(count), 32'd3);
        drive(1'b0, 16'h0, 1'b1, got); check("ord_pop0", 32'(got), 32'h0011);
        drive(1'b0, 16'h0, 1'b1, got); check("ord_pop1", 32'(got), 32'h0022);
        drive(1'b0, 16'h0, 1'b1, got); check("ord_pop2", 32'(got), 32'h0033);
        check("ord_empty", 32'(empty), 32'd1);

        // Fill, overflow attempt, then simultaneous push+pop when full
        for (int i = 0; i < 1024; i++) drive(1'b1, 16'(i) ^ 16'hA5C3, 1'b0, got);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd1024);
        drive(1'b1, 16'hBEEF, 1'b0, got);
        check("ovf_count", 32'(count), 32'd1024);
`ifdef DPR_FIFO_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'd1);
`endif
        drive(1'b1, 16'h1234, 1'b1, got);
        check("full_pp_count", 32'(count), 32'd1023);
        check("full_pp_data", 32'(got), 32'hA5C3);

        // Steady state at occupancy 5
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, got);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0105 + 16'(i), 1'b1, got);
            check("ss_data", 32'(got), 32'(16'h0100 + 16'(i)));
        end
        check("ss_count", 32'(count), 32'd5);

        // Wrap: 1030 entries, occupancy 4
        do_reset();
        exp_seq = 16'h0;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(i), 1'b0, got);
        for (int i = 4; i < 1030; i++) begin
            if (i == 1024) check("wrap_add_wr", 32'(ram_add_wr), 32'd0);
            drive(1'b1, 16'(i), 1'b1, got);
            check("wrap_data", 32'(got), 32'(exp_seq));
            exp_seq = exp_seq + 16'd1;
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_seq == 16'd1024) check("wrap_add_rd", 32'(ram_add_rd), 32'd0);
            drive(1'b0, 16'h0, 1'b1, got);
            check("wrap_data", 32'(got), 32'(exp_seq));
            exp_seq = exp_seq + 16'd1;
        end
        check("wrap_total", 32'(exp_seq), 32'd1030);
        check("wrap_empty", 32'(empty), 32'd1);

        // Underflow, then reset right after an accepted pop
        drive(1'b0, 16'h0, 1'b1, got);
        check("udf_pop_valid", 32'(pop_valid), 32'd0);
`ifdef DPR_FIFO_ERR_FLAGS_EN
        check("underflow", 32'(underflow), 32'd1);
`endif
        drive(1'b1, 16'h7777, 1'b0, got);
        drive(1'b1, 16'h8888, 1'b0, got);
        drive(1'b0, 16'h0, 1'b1, got);
        check("pre_rst_valid", 32'(pop_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(pop_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mcount = 0; mwp = '0; mrp = '0; sb.delete();
        drive(1'b0, 16'h0, 1'b1, got);
        check("post_rst_valid", 32'(pop_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
